// File: rtl/hss_pkg.sv
// ============================================================================
// Module : hss_pkg
// Brief  : Shared types, constants and helpers for the HSS feature pipeline.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hss_pkg;

    localparam int HSS_D_WIDTH = 16;

    localparam logic signed [HSS_D_WIDTH-1:0] HSS_SMIN = {1'b1, {(HSS_D_WIDTH-1){1'b0}}};

    // Helper operates at a fixed wide width; callers sign-extend and truncate.
    localparam int SMAX_W = 32;

    function automatic logic signed [SMAX_W-1:0] smax(
        input logic signed [SMAX_W-1:0] a,
        input logic signed [SMAX_W-1:0] b
    );
        // Ties keep a.
        return (b > a) ? b : a;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_maxpool.sv
// ============================================================================
// Module : conv_maxpool
// Brief  : Optional ReLU plus non-overlapping signed max-pooling (decimate by POOL).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_maxpool
    import hss_pkg::*;
#(
    parameter int D_WIDTH = HSS_D_WIDTH,
    parameter int POOL    = 2,
    parameter int RELU    = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_parity,
    input  logic [D_WIDTH-1:0] input_data,
    input  logic               in_write_enable,
    output logic [D_WIDTH-1:0] output_data,
    output logic               out_parity,
    output logic               write_enable
);

    localparam int CNT_W = (POOL > 1) ? $clog2(POOL) : 1;

    localparam logic [CNT_W-1:0]          C_LAST = CNT_W'(POOL - 1);
    localparam logic signed [D_WIDTH-1:0] C_SMIN = {1'b1, {(D_WIDTH-1){1'b0}}};

    logic [CNT_W-1:0]          r_cnt;
    logic signed [D_WIDTH-1:0] r_acc;
    logic                      r_last_parity;

    logic                      w_first;
    logic [CNT_W-1:0]          w_pos;
    logic signed [D_WIDTH-1:0] w_max;
    logic signed [D_WIDTH-1:0] w_pooled;
    logic                      w_close;

    // A parity change mid-window restarts the window on the incoming sample.
    always_comb begin
        w_first  = (r_cnt == '0) || (in_parity != r_last_parity);
        w_pos    = w_first ? '0 : r_cnt;
        w_max    = w_first ? $signed(input_data)
                           : D_WIDTH'(smax(SMAX_W'(r_acc), SMAX_W'($signed(input_data))));
        w_close  = (w_pos == C_LAST);
        w_pooled = ((RELU != 0) && w_max[D_WIDTH-1]) ? '0 : w_max;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            output_data   <= '0;
            out_parity    <= 1'b0;
            write_enable  <= 1'b0;
            r_cnt         <= '0;
            r_acc         <= C_SMIN;
            r_last_parity <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            if (in_write_enable) begin
                r_last_parity <= in_parity;
                r_acc         <= w_max;
                if (w_close) begin
                    output_data  <= w_pooled;
                    write_enable <= 1'b1;
                    out_parity   <= ~out_parity;
                    r_cnt        <= '0;
                end else begin
                    r_cnt <= w_pos + CNT_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_maxpool.sv
// ============================================================================
// Module : tb_conv_maxpool
// Brief  : Directed self-checking bench for conv_maxpool in several configurations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_conv_maxpool;

    logic        clk = 1'b0;
    logic        rst;
    logic        par;
    logic [15:0] din;
    logic        we;

    logic [15:0] d2,  d2n,  d4,  d1;
    logic        p2,  p2n,  p4,  p1;
    logic        w2,  w2n,  w4,  w1;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    conv_maxpool #(.D_WIDTH(16), .POOL(2), .RELU(1)) u_p2r1 (
        .CLK(clk), .RST(rst), .in_parity(par), .input_data(din), .in_write_enable(we),
        .output_data(d2), .out_parity(p2), .write_enable(w2));
    conv_maxpool #(.D_WIDTH(16), .POOL(2), .RELU(0)) u_p2r0 (
        .CLK(clk), .RST(rst), .in_parity(par), .input_data(din), .in_write_enable(we),
        .output_data(d2n), .out_parity(p2n), .write_enable(w2n));
    conv_maxpool #(.D_WIDTH(16), .POOL(4), .RELU(1)) u_p4r1 (
        .CLK(clk), .RST(rst), .in_parity(par), .input_data(din), .in_write_enable(we),
        .output_data(d4), .out_parity(p4), .write_enable(w4));
    conv_maxpool #(.D_WIDTH(16), .POOL(1), .RELU(1)) u_p1r1 (
        .CLK(clk), .RST(rst), .in_parity(par), .input_data(din), .in_write_enable(we),
        .output_data(d1), .out_parity(p1), .write_enable(w1));

    // One clock edge with the given inputs; outputs are sampled 1 time unit after it.
    task automatic step(input logic r, input logic s, input logic [15:0] d, input logic p);
        rst = r; we = s; din = d; par = p;
        @(posedge clk);
        #1;
        rst = 1'b0; we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, par);
    endtask

    task automatic do_reset;
        step(1'b1, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1, 16'h7777, 1'b1);
        vectors++; if ({d2, p2, w2} !== 18'h0) begin miscompares++;
            $display("FAIL reset_p2 got %h/%b/%b want 0000/0/0", d2, p2, w2); end
        vectors++; if ({d4, p4, w4} !== 18'h0) begin miscompares++;
            $display("FAIL reset_p4 got %h/%b/%b want 0000/0/0", d4, p4, w4); end
        vectors++; if ({d1, p1, w1} !== 18'h0) begin miscompares++;
            $display("FAIL reset_p1 got %h/%b/%b want 0000/0/0", d1, p1, w1); end
    endtask

    task automatic test_basic;
        do_reset();
        step(1'b0, 1'b1, 16'h0100, 1'b0);
        vectors++; if (w2 !== 1'b0) begin miscompares++;
            $display("FAIL basic_we_early got %b want 0", w2); end
        step(1'b0, 1'b1, 16'hFF00, 1'b0);
        vectors++; if ({d2, p2, w2} !== {16'h0100, 1'b1, 1'b1}) begin miscompares++;
            $display("FAIL basic_out got %h/%b/%b want 0100/1/1", d2, p2, w2); end
        vectors++; if ({d1, p1, w1} !== {16'h0000, 1'b0, 1'b1}) begin miscompares++;
            $display("FAIL pool1_out got %h/%b/%b want 0000/0/1", d1, p1, w1); end
        idle(1);
        vectors++; if ({d2, p2, w2} !== {16'h0100, 1'b1, 1'b0}) begin miscompares++;
            $display("FAIL basic_hold got %h/%b/%b want 0100/1/0", d2, p2, w2); end
    endtask

    task automatic test_relu;
        do_reset();
        step(1'b0, 1'b1, 16'hFFF0, 1'b0);
        step(1'b0, 1'b1, 16'hFFE0, 1'b0);
        vectors++; if ({d2, w2} !== {16'h0000, 1'b1}) begin miscompares++;
            $display("FAIL relu_on got %h/%b want 0000/1", d2, w2); end
        vectors++; if ({d2n, w2n} !== {16'hFFF0, 1'b1}) begin miscompares++;
            $display("FAIL relu_off got %h/%b want fff0/1", d2n, w2n); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] vec [8];
        vec = '{16'h0200, 16'h04A0, 16'h06B0, 16'h08C0, 16'h0010, 16'h0020, 16'h0030, 16'h0040};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, vec[i], 1'b0);
            vectors++; if (w4 !== ((i == 3) || (i == 7))) begin miscompares++;
                $display("FAIL b2b_we[%0d] got %b", i, w4); end
            if (i == 3) begin
                vectors++; if ({d4, p4} !== {16'h08C0, 1'b1}) begin miscompares++;
                    $display("FAIL b2b_out0 got %h/%b want 08c0/1", d4, p4); end
            end
            if (i == 7) begin
                vectors++; if ({d4, p4} !== {16'h0040, 1'b0}) begin miscompares++;
                    $display("FAIL b2b_out1 got %h/%b want 0040/0", d4, p4); end
                vectors++; if ({d2, p2} !== {16'h0040, 1'b0}) begin miscompares++;
                    $display("FAIL b2b_p2 got %h/%b want 0040/0", d2, p2); end
            end
        end
    endtask

    task automatic test_segment;
        logic [15:0] vec [6];
        vec = '{16'h0300, 16'h0500, 16'h0100, 16'h0200, 16'h0050, 16'h0080};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, vec[i], (i >= 2));
            vectors++; if (w4 !== (i == 5)) begin miscompares++;
                $display("FAIL seg_we[%0d] got %b", i, w4); end
            if (i == 3) begin
                vectors++; if ({d2, w2} !== {16'h0200, 1'b1}) begin miscompares++;
                    $display("FAIL seg_p2 got %h/%b want 0200/1", d2, w2); end
            end
        end
        vectors++; if ({d4, p4} !== {16'h0200, 1'b1}) begin miscompares++;
            $display("FAIL seg_out got %h/%b want 0200/1", d4, p4); end
    endtask

    task automatic test_gaps;
        do_reset();
        step(1'b0, 1'b1, 16'h0011, 1'b0);
        idle(1);
        vectors++; if (w2 !== 1'b0) begin miscompares++;
            $display("FAIL gap_we0 got %b want 0", w2); end
        step(1'b0, 1'b1, 16'h0022, 1'b0);
        vectors++; if ({d2, p2, w2} !== {16'h0022, 1'b1, 1'b1}) begin miscompares++;
            $display("FAIL gap_out0 got %h/%b/%b want 0022/1/1", d2, p2, w2); end
        idle(3);
        step(1'b0, 1'b1, 16'h7FFF, 1'b0);
        vectors++; if ({d2, w2} !== {16'h0022, 1'b0}) begin miscompares++;
            $display("FAIL gap_hold got %h/%b want 0022/0", d2, w2); end
        idle(7);
        step(1'b0, 1'b1, 16'h8000, 1'b0);
        vectors++; if ({d2, p2, w2} !== {16'h7FFF, 1'b0, 1'b1}) begin miscompares++;
            $display("FAIL gap_out1 got %h/%b/%b want 7fff/0/1", d2, p2, w2); end
        vectors++; if ({d2n, w2n} !== {16'h7FFF, 1'b1}) begin miscompares++;
            $display("FAIL gap_min got %h/%b want 7fff/1", d2n, w2n); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        step(1'b0, 1'b1, 16'h0700, 1'b0);
        step(1'b0, 1'b1, 16'h0600, 1'b0);
        step(1'b0, 1'b1, 16'h0500, 1'b0);
        step(1'b1, 1'b1, 16'h0900, 1'b0);
        vectors++; if ({d4, p4, w4} !== 18'h0) begin miscompares++;
            $display("FAIL rstmid_clr got %h/%b/%b want 0000/0/0", d4, p4, w4); end
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 16'(i), 1'b0);
            vectors++; if (w4 !== (i == 4)) begin miscompares++;
                $display("FAIL rstmid_we[%0d] got %b", i, w4); end
        end
        vectors++; if ({d4, p4} !== {16'h0004, 1'b1}) begin miscompares++;
            $display("FAIL rstmid_out got %h/%b want 0004/1", d4, p4); end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; din = '0; par = 1'b0;
        test_reset();
        test_basic();
        test_relu();
        test_back_to_back();
        test_segment();
        test_gaps();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
